// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver.
//
// Receives asynchronous frames on rx (idle high): one start bit, DATA_BITS
// data bits LSB first, an optional parity bit and STOP_BITS stop bits.
// Every completed word goes out on a valid/ready stream together with its
// parity and framing error flags.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     1 or 2
//   FIFO_DEPTH    receive FIFO entries, power of two >= 2 (FIFO build only)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   rx            asynchronous serial input
//   m_data        received word, bit 0 = first data bit on the line
//   m_parity_err  parity mismatch for the word on m_data
//   m_frame_err   a stop bit of that word sampled low
//   m_valid       word available
//   m_ready       consumer takes the word when m_valid && m_ready
//   overrun       one-cycle pulse: a completed word was dropped (buffer full)
//   busy          receiver FSM is not idle
//
// Build option: define UART_RX_FIFO_EN for a first-word-fall-through FIFO
// of FIFO_DEPTH entries; otherwise a single holding register is used.

module uart_rx_param #(
  parameter int CLKS_PER_BIT = 65,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_MID   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
      $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
      $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_sb
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fd
      $error("uart_rx_param: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } word_t;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------- sync
  logic rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;       // data bit / stop bit index
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  // Set when a frame ends with the line low (break): a new start is only
  // accepted once the line has been seen high again.
  logic                 wait_hi, wait_hi_n;
  logic                 push;
  word_t                push_word;
  logic                 tick;

  assign tick = (cnt == CNT_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      wait_hi <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      sh      <= sh_n;
      perr    <= perr_n;
      ferr    <= ferr_n;
      wait_hi <= wait_hi_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    idx_n     = idx;
    sh_n      = sh;
    perr_n    = perr;
    ferr_n    = ferr;
    wait_hi_n = wait_hi;
    push      = 1'b0;
    push_word = '0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (rx_s) wait_hi_n = 1'b0;
        if (!rx_s && !wait_hi) begin
          state_n = S_START;
          idx_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      S_START: begin
        if (cnt == CNT_MID) begin
          // cnt restarts here so later samples land at mid-bit
          cnt_n   = '0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[DATA_BITS-1:1]};
          idx_n = idx + 4'd1;
          if (idx == DATA_LAST) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          perr_n  = ((^sh) ^ rx_s) != (PARITY == 1);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_n = '0;
          if (!rx_s) ferr_n = 1'b1;
          if (idx == STOP_LAST) begin
            // Return to IDLE right away so a start edge in the second half
            // of the stop bit is still caught.
            push      = 1'b1;
            state_n   = S_IDLE;
            wait_hi_n = !rx_s;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    push_word.data = sh;
    push_word.perr = perr;
    push_word.ferr = ferr_n;
  end

  assign busy = (state != S_IDLE);

  // ---------------------------------------------------------------- buffer
  logic  push_ok;
  word_t out_word;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  word_t         mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          full, pop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign m_valid  = (count != '0);
  assign pop      = m_valid && m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop);
  assign out_word = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= push_word;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
`else
  word_t hold;
  logic  hold_v;

  assign m_valid  = hold_v;
  assign push_ok  = push && (!hold_v || m_ready);
  assign out_word = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold   <= '0;
      hold_v <= 1'b0;
    end else if (push_ok) begin
      hold   <= push_word;
      hold_v <= 1'b1;
    end else if (hold_v && m_ready) begin
      hold_v <= 1'b0;
    end
  end
`endif

  assign m_data       = out_word.data;
  assign m_parity_err = out_word.perr;
  assign m_frame_err  = out_word.ferr;

  always_ff @(posedge clk) begin
    if (reset) overrun <= 1'b0;
    else       overrun <= push && !push_ok;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Two instances share clk/reset:
//   A: 65 clocks/bit, 8N1  (main checks, overrun, reset, break)
//   B: 16 clocks/bit, 8E2  (parity, two stop bits, random backpressure)
// Words received are collected by a monitor; each test task compares them
// against values derived from the frame contents it put on the line.
module tb_uart_rx_param;

  localparam int CPB_A = 65;
  localparam int CPB_B = 16;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic reset, rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic pe_a, fe_a, v_a, ov_a, busy_a;
  logic pe_b, fe_b, v_b, ov_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .rx(rx_a), .m_data(data_a),
    .m_parity_err(pe_a), .m_frame_err(fe_a), .m_valid(v_a),
    .m_ready(rdy_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .rx(rx_b), .m_data(data_b),
    .m_parity_err(pe_b), .m_frame_err(fe_b), .m_valid(v_b),
    .m_ready(rdy_b), .overrun(ov_b), .busy(busy_b));

  int total = 0;
  int bad   = 0;

  logic [9:0] got_a[$];
  logic [9:0] got_b[$];
  int ov_cnt_a = 0, ov_cnt_b = 0, stab_b = 0;
  logic       hold_b = 1'b0;
  logic [9:0] last_b = '0;
  logic       tog_b = 1'b0;

  // monitor: record accepted words, overrun pulses, stalled-word stability
  always @(negedge clk) begin
    if (v_a && rdy_a) got_a.push_back({data_a, pe_a, fe_a});
    if (v_b && rdy_b) got_b.push_back({data_b, pe_b, fe_b});
    if (ov_a) ov_cnt_a++;
    if (ov_b) ov_cnt_b++;
    if (hold_b && !reset && ({data_b, pe_b, fe_b} !== last_b)) stab_b++;
    hold_b = v_b && !rdy_b && !reset;
    last_b = {data_b, pe_b, fe_b};
  end

  // random consumer backpressure on B
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tog_b) rdy_b = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected word from the line contents. B uses even parity: the data
  // ones plus the parity bit must be an even count.
  function automatic logic [9:0] model(input int which, input logic [7:0] d,
                                       input logic p, input logic s0, input logic s1);
    logic perr, ferr;
    perr = (which == 1) ? ((($countones(d) + int'(p)) % 2) != 0) : 1'b0;
    ferr = !s0 || ((which == 1) && !s1);
    return {d, perr, ferr};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic p,
                      input logic s0, input logic s1);
    bit q[$];
    int cpb;
    cpb = (which == 1) ? CPB_B : CPB_A;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (which == 1) q.push_back(p);
    q.push_back(s0);
    if (which == 1) q.push_back(s1);
    foreach (q[i]) begin
      if (which == 1) rx_b = q[i]; else rx_a = q[i];
      idle(cpb);
    end
    if (which == 1) rx_b = 1'b1; else rx_a = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    idle(4);
    reset = 1'b0;
    @(negedge clk);
    if (v_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", v_a); end
    total++;
    if (data_a !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_a); end
    total++;
    if ({pe_a, fe_a} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {pe_a, fe_a}); end
    total++;
    if (ov_a !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", ov_a); end
    total++;
    if ({busy_a, busy_b, v_b} !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b want=000", {busy_a, busy_b, v_b}); end
    total++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int base;
    logic [9:0] exp_w;
    got_a.delete();
    base = ov_cnt_a;
    exp_w = model(0, 8'h41, 1'b0, 1'b1, 1'b1);
    send(0, 8'h41, 1'b0, 1'b1, 1'b1);
    idle(3 * CPB_A);
    if (got_a.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d want=1", got_a.size()); end
    total++;
    if (got_a.size() > 0) begin
      if (got_a[0] !== exp_w) begin bad++; $display("FAIL basic_word got=%h want=%h", got_a[0], exp_w); end
      total++;
    end
    if (ov_cnt_a - base !== 0) begin bad++; $display("FAIL basic_overrun got=%0d want=0", ov_cnt_a - base); end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy_a); end
    total++;
  endtask

  task automatic test_false_start;
    bit seen_busy;
    int waited;
    got_a.delete();
    seen_busy = 0;
    rx_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) seen_busy = 1;
    end
    @(posedge clk); #1;
    rx_a = 1'b1;
    waited = 0;
    while (busy_a && waited < 35) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!seen_busy) begin bad++; $display("FAIL false_start_busy_rise got=0 want=1"); end
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL false_start_busy_fall got=%b want=0 after %0d cycles", busy_a, waited); end
    total++;
    idle(3 * CPB_A);
    if (got_a.size() !== 0) begin bad++; $display("FAIL false_start_words got=%0d want=0", got_a.size()); end
    total++;
  endtask

  task automatic test_frame_err;
    logic [9:0] e0, e1;
    got_a.delete();
    e0 = model(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    e1 = model(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(2 * CPB_A);
    send(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB_A);
    if (got_a.size() !== 2) begin bad++; $display("FAIL frame_count got=%0d want=2", got_a.size()); end
    total++;
    if (got_a.size() == 2) begin
      if (got_a[0] !== e0) begin bad++; $display("FAIL frame_bad got=%h want=%h", got_a[0], e0); end
      total++;
      if (got_a[1] !== e1) begin bad++; $display("FAIL frame_good got=%h want=%h", got_a[1], e1); end
      total++;
    end
  endtask

  task automatic test_break;
    got_a.delete();
    rx_a = 1'b0;
    idle(12 * CPB_A);
    rx_a = 1'b1;
    idle(3 * CPB_A);
    if (got_a.size() !== 1) begin bad++; $display("FAIL break_count got=%0d want=1", got_a.size()); end
    total++;
    if (got_a.size() > 0) begin
      if (got_a[0] !== {8'h00, 1'b0, 1'b1}) begin bad++; $display("FAIL break_word got=%h want=%h", got_a[0], {8'h00, 1'b0, 1'b1}); end
      total++;
    end
  endtask

  task automatic test_parity;
    logic [9:0] e0, e1;
    got_b.delete();
    tog_b = 1'b1;
    e0 = model(1, 8'h03, 1'b1, 1'b1, 1'b1);
    e1 = model(1, 8'h03, 1'b0, 1'b1, 1'b1);
    send(1, 8'h03, 1'b1, 1'b1, 1'b1);
    idle(2 * CPB_B);
    send(1, 8'h03, 1'b0, 1'b1, 1'b1);
    idle(4 * CPB_B);
    if (got_b.size() !== 2) begin bad++; $display("FAIL parity_count got=%0d want=2", got_b.size()); end
    total++;
    if (got_b.size() == 2) begin
      if (got_b[0] !== e0) begin bad++; $display("FAIL parity_err_set got=%h want=%h", got_b[0], e0); end
      total++;
      if (got_b[1] !== e1) begin bad++; $display("FAIL parity_err_clear got=%h want=%h", got_b[1], e1); end
      total++;
    end
  endtask

  task automatic test_random;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [7:0] d;
    logic p, s0, s1;
    int base_ov, base_stab;
    got_a.delete(); got_b.delete();
    base_ov = ov_cnt_a + ov_cnt_b;
    base_stab = stab_b;
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      s0 = ($urandom_range(0, 3) != 0);
      exp_a.push_back(model(0, d, 1'b0, s0, 1'b1));
      send(0, d, 1'b0, s0, 1'b1);
      idle($urandom_range(CPB_A, 3 * CPB_A));
    end
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      exp_b.push_back(model(1, d, p, s0, s1));
      send(1, d, p, s0, s1);
      idle($urandom_range(CPB_B, 4 * CPB_B));
    end
    idle(4 * CPB_B);
    if (got_a.size() !== exp_a.size()) begin bad++; $display("FAIL rand_a_count got=%0d want=%0d", got_a.size(), exp_a.size()); end
    total++;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL rand_a_word[%0d] got=%h want=%h", i, got_a[i], exp_a[i]); end
      total++;
    end
    if (got_b.size() !== exp_b.size()) begin bad++; $display("FAIL rand_b_count got=%0d want=%0d", got_b.size(), exp_b.size()); end
    total++;
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      if (got_b[i] !== exp_b[i]) begin bad++; $display("FAIL rand_b_word[%0d] got=%h want=%h", i, got_b[i], exp_b[i]); end
      total++;
    end
    if (ov_cnt_a + ov_cnt_b - base_ov !== 0) begin bad++; $display("FAIL rand_overrun got=%0d want=0", ov_cnt_a + ov_cnt_b - base_ov); end
    total++;
    if (stab_b - base_stab !== 0) begin bad++; $display("FAIL rand_stall_stability got=%0d changes want=0", stab_b - base_stab); end
    total++;
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_a[$];
    logic [7:0] d;
    got_a.delete();
    rdy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      exp_a.push_back(model(0, d, 1'b0, 1'b1, 1'b1));
      send(0, d, 1'b0, 1'b1, 1'b1);
    end
    idle(2 * CPB_A);
    if (got_a.size() !== 5) begin bad++; $display("FAIL b2b_count got=%0d want=5", got_a.size()); end
    total++;
    for (int i = 0; i < 5 && i < got_a.size(); i++) begin
      if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, got_a[i], exp_a[i]); end
      total++;
    end
  endtask

  task automatic test_overrun;
    int base;
    got_a.delete();
    base = ov_cnt_a;
    rdy_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(0, 8'(8'h10 + i), 1'b0, 1'b1, 1'b1);
      idle(CPB_A);
    end
    @(negedge clk);
    if (ov_cnt_a - base !== 5 - CAP) begin bad++; $display("FAIL overrun_pulses got=%0d want=%0d", ov_cnt_a - base, 5 - CAP); end
    total++;
    if ({v_a, data_a} !== {1'b1, 8'h10}) begin bad++; $display("FAIL overrun_head got=%b/%h want=1/10", v_a, data_a); end
    total++;
    @(posedge clk); #1;
    rdy_a = 1'b1;
    idle(10);
    if (got_a.size() !== CAP) begin bad++; $display("FAIL overrun_drain_count got=%0d want=%0d", got_a.size(), CAP); end
    total++;
    for (int i = 0; i < CAP && i < got_a.size(); i++) begin
      if (got_a[i] !== {8'(8'h10 + i), 2'b00}) begin bad++; $display("FAIL overrun_drain[%0d] got=%h want=%h", i, got_a[i], {8'(8'h10 + i), 2'b00}); end
      total++;
    end
  endtask

  task automatic test_reset_mid;
    got_a.delete();
    rdy_a = 1'b0;
    send(0, 8'h33, 1'b0, 1'b1, 1'b1);
    idle(CPB_A);
    if (v_a !== 1'b1) begin bad++; $display("FAIL reset_mid_buffered got=%b want=1", v_a); end
    total++;
    // start bit and first data bits of 0x77, then reset inside a data bit
    rx_a = 1'b0; idle(CPB_A);
    rx_a = 1'b1; idle(2 * CPB_A);
    idle(30);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clk);
    if ({busy_a, v_a} !== 2'b00) begin bad++; $display("FAIL reset_mid_state got=%b want=00", {busy_a, v_a}); end
    total++;
    @(posedge clk); #1;
    idle(3 * CPB_A);
    rdy_a = 1'b1;
    send(0, 8'h42, 1'b0, 1'b1, 1'b1);
    idle(2 * CPB_A);
    if (got_a.size() !== 1) begin bad++; $display("FAIL reset_mid_count got=%0d want=1", got_a.size()); end
    total++;
    if (got_a.size() > 0) begin
      if (got_a[0] !== {8'h42, 2'b00}) begin bad++; $display("FAIL reset_mid_word got=%h want=%h", got_a[0], {8'h42, 2'b00}); end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_break();
    test_parity();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
